// File: rtl/game_countdown_timer.sv
// Round countdown timer: 1 s prescaler, pause/restart, time_up pulse and low-time warn/blink.
// Optional feature macro: TIMER_BONUS_EN adds the bonus_req port that extends the round.
module game_countdown_timer #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned START_SEC = 10,
    parameter int unsigned WARN_SEC  = 3,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned BONUS_SEC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       cnt_enable,
`ifdef TIMER_BONUS_EN
    input  logic       bonus_req,
`endif
    output logic [3:0] time_remain,
    output logic       tick_1hz,
    output logic       time_up,
    output logic       warn,
    output logic       blink
);

    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [3:0]       START_V  = 4'(START_SEC);
    localparam logic [3:0]       WARN_V   = 4'(WARN_SEC);

    logic [3:0]       time_remain_q, time_remain_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             tick_q, tick_d;
    logic             time_up_q, time_up_d;
    logic             blink_q, blink_d;
    logic             dec_s;
    logic             warn_s;

`ifdef TIMER_BONUS_EN
    // Bonus seconds are applied after any coinciding decrement and clip at the 4-bit maximum.
    function automatic logic [3:0] bonus_sum(input logic [3:0] cur, input logic dec);
        logic [5:0] sum;
        sum = 6'(cur) - 6'(dec) + 6'(BONUS_SEC);
        if (sum > 6'd15) begin
            return 4'd15;
        end else begin
            return sum[3:0];
        end
    endfunction
`endif

    // Warn is deliberately combinational so the display sees it in the same cycle as time_remain.
    assign warn_s = cnt_enable && (time_remain_q != 4'd0) && (time_remain_q <= WARN_V);

    // Next-state for the seconds counter, prescaler and the tick/time_up pulses.
    always_comb begin
        time_remain_d = time_remain_q;
        pre_d         = pre_q;
        tick_d        = 1'b0;
        time_up_d     = 1'b0;
        dec_s         = 1'b0;
        if (game_start) begin
            time_remain_d = START_V;
            pre_d         = '0;
        end else if (cnt_enable && (time_remain_q != 4'd0)) begin
            dec_s  = (pre_q == PRE_LAST);
            pre_d  = dec_s ? '0 : pre_q + PRE_W'(1);
            tick_d = dec_s;
`ifdef TIMER_BONUS_EN
            if (bonus_req) begin
                time_remain_d = bonus_sum(time_remain_q, dec_s);
            end else begin
                time_remain_d = time_remain_q - 4'(dec_s);
                time_up_d     = dec_s && (time_remain_q == 4'd1);
            end
`else
            time_remain_d = time_remain_q - 4'(dec_s);
            time_up_d     = dec_s && (time_remain_q == 4'd1);
`endif
        end else begin
            time_remain_d = time_remain_q;
            pre_d         = pre_q;
        end
    end

    // Blink divider free-runs only while warn is high and clears as soon as warn drops.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (warn_s) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d = '0;
                blink_d   = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
                blink_d   = blink_q;
            end
        end else begin
            blk_cnt_d = '0;
            blink_d   = 1'b0;
        end
    end

    // State registers with asynchronous reset back to the start-of-round values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_remain_q <= START_V;
            pre_q         <= '0;
            blk_cnt_q     <= '0;
            tick_q        <= 1'b0;
            time_up_q     <= 1'b0;
            blink_q       <= 1'b0;
        end else begin
            time_remain_q <= time_remain_d;
            pre_q         <= pre_d;
            blk_cnt_q     <= blk_cnt_d;
            tick_q        <= tick_d;
            time_up_q     <= time_up_d;
            blink_q       <= blink_d;
        end
    end

    assign time_remain = time_remain_q;
    assign tick_1hz    = tick_q;
    assign time_up     = time_up_q;
    assign warn        = warn_s;
    assign blink       = blink_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Randomized bench for game_countdown_timer against a seconds-level reference model.
// Build with TIMER_BONUS_EN defined to exercise the bonus_req path as well.
module tb_game_countdown_timer;

    localparam int CLK_HZ    = 10;
    localparam int START_SEC = 10;
    localparam int WARN_SEC  = 3;
    localparam int BLINK_DIV = 2;
    localparam int BONUS_SEC = 2;
`ifdef TIMER_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       game_start;
    logic       cnt_enable;
    logic       bonus_req;
    logic [3:0] time_remain;
    logic       tick_1hz;
    logic       time_up;
    logic       warn;
    logic       blink;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: whole seconds left, enabled cycles into the current second,
    // and how many consecutive cycles warn has been high.
    int m_tr;
    int m_sub;
    int m_wrun;
    bit m_tick;
    bit m_up;
    bit m_blink;
    int up_count;

    game_countdown_timer #(
        .CLK_HZ(CLK_HZ),
        .START_SEC(START_SEC),
        .WARN_SEC(WARN_SEC),
        .BLINK_DIV(BLINK_DIV),
        .BONUS_SEC(BONUS_SEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .game_start(game_start),
        .cnt_enable(cnt_enable),
`ifdef TIMER_BONUS_EN
        .bonus_req(bonus_req),
`endif
        .time_remain(time_remain),
        .tick_1hz(tick_1hz),
        .time_up(time_up),
        .warn(warn),
        .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tr    = START_SEC;
        m_sub   = 0;
        m_wrun  = 0;
        m_tick  = 1'b0;
        m_up    = 1'b0;
        m_blink = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model by the rules, then compare after the edge.
    task automatic step(input bit gs, input bit en, input bit bn);
        bit wn;
        bit dec;
        bit bon;
        game_start = gs;
        cnt_enable = en;
        bonus_req  = bn;
        bon = BONUS_ON && bn;
        wn  = en && (m_tr > 0) && (m_tr <= WARN_SEC);
        if (wn) begin
            m_wrun++;
            m_blink = ((m_wrun / BLINK_DIV) % 2) == 1;
        end else begin
            m_wrun  = 0;
            m_blink = 1'b0;
        end
        m_tick = 1'b0;
        m_up   = 1'b0;
        if (gs) begin
            m_tr  = START_SEC;
            m_sub = 0;
        end else if (en && (m_tr > 0)) begin
            m_sub++;
            dec = (m_sub == CLK_HZ);
            if (dec) m_sub = 0;
            m_tick = dec;
            if (bon) begin
                m_tr = m_tr - int'(dec) + BONUS_SEC;
                if (m_tr > 15) m_tr = 15;
            end else begin
                m_up = dec && (m_tr == 1);
                m_tr = m_tr - int'(dec);
            end
        end
        if (m_up) up_count++;
        @(posedge clk);
        #1;
        chk_eq("time_remain", 32'(time_remain), 32'(m_tr));
        chk_eq("tick_1hz", 32'(tick_1hz), 32'(m_tick));
        chk_eq("time_up", 32'(time_up), 32'(m_up));
        chk_eq("blink", 32'(blink), 32'(m_blink));
        chk_eq("warn", 32'(warn), 32'(en && (m_tr > 0) && (m_tr <= WARN_SEC)));
    endtask

    // Asynchronous reset between clock edges; outputs must return to reset values immediately.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk_eq("rst_time_remain", 32'(time_remain), 32'(START_SEC));
        chk_eq("rst_tick", 32'(tick_1hz), 32'd0);
        chk_eq("rst_time_up", 32'(time_up), 32'd0);
        chk_eq("rst_blink", 32'(blink), 32'd0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        game_start = 1'b0;
        cnt_enable = 1'b0;
        bonus_req  = 1'b0;
        up_count   = 0;
        model_reset();
        #22 rst = 1'b0;
        #1;
        chk_eq("reset_time_remain", 32'(time_remain), 32'd10);
        chk_eq("reset_tick", 32'(tick_1hz), 32'd0);
        chk_eq("reset_time_up", 32'(time_up), 32'd0);
        chk_eq("reset_warn", 32'(warn), 32'd0);
        chk_eq("reset_blink", 32'(blink), 32'd0);

        // First decrement lands exactly CLK_HZ enabled cycles after game_start.
        step(1'b1, 1'b1, 1'b0);
        up_count = 0;
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("first_sec_hold", 32'(time_remain), 32'd10);
        step(1'b0, 1'b1, 1'b0);
        chk_eq("first_dec", 32'(time_remain), 32'd9);
        chk_eq("first_tick", 32'(tick_1hz), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk_eq("tick_one_cycle", 32'(tick_1hz), 32'd0);

        // Run to zero and beyond: one time_up, no wrap, warn/blink clear.
        for (int i = 0; i < 139; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("zero_hold", 32'(time_remain), 32'd0);
        chk_eq("single_time_up", 32'(up_count), 32'd1);
        chk_eq("zero_blink", 32'(blink), 32'd0);

        // Pause mid-second keeps the partial second.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 37; i++) step(1'b0, 1'b0, 1'b0);
        chk_eq("pause_hold", 32'(time_remain), 32'd10);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("resume_partial", 32'(time_remain), 32'd10);
        step(1'b0, 1'b1, 1'b0);
        chk_eq("resume_dec", 32'(time_remain), 32'd9);

        // Restart coinciding with the terminal prescaler count at 5 s.
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b0);
        chk_eq("at_five", 32'(time_remain), 32'd5);
        step(1'b1, 1'b1, 1'b0);
        chk_eq("restart_value", 32'(time_remain), 32'd10);
        chk_eq("restart_no_tick", 32'(tick_1hz), 32'd0);
        chk_eq("restart_no_up", 32'(time_up), 32'd0);

        // Reset in the middle of a round.
        for (int i = 0; i < 23; i++) step(1'b0, 1'b1, 1'b0);
        do_reset();

`ifdef TIMER_BONUS_EN
        step(1'b1, 1'b1, 1'b1);
        chk_eq("bonus_with_start", 32'(time_remain), 32'd10);
        step(1'b0, 1'b0, 1'b1);
        chk_eq("bonus_paused", 32'(time_remain), 32'd10);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk_eq("bonus_14", 32'(time_remain), 32'd14);
        step(1'b0, 1'b1, 1'b1);
        chk_eq("bonus_saturate", 32'(time_remain), 32'd15);
        guard = 0;
        while (!((m_tr == 1) && (m_sub == CLK_HZ - 1)) && (guard < 3000)) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk_eq("bonus_reach_bound", 32'(guard < 3000), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk_eq("bonus_tick_value", 32'(time_remain), 32'd2);
        chk_eq("bonus_tick_pulse", 32'(tick_1hz), 32'd1);
        chk_eq("bonus_no_up", 32'(time_up), 32'd0);
`endif

        // Random traffic: occasional restarts, pauses, bonus requests and resets.
        guard = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                     $urandom_range(0, 19) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
